traffic_countdown_display: RTL and testbench
============================================

// Module: traffic_countdown_display
// PURPOSE
//  Downstream consumer of the two-way traffic light controller. Watches the
//  G/Y/R light outputs of both directions and the Tgreen/Tyellow/Tred
//  durations that drive the controller. Runs one countdown per direction,
//  showing the time left in the current phase as binary, BCD and 7-segment.
//  Flags illegal light patterns.
// PARAMETERS
//  CW       6   width of durations and counters (max 63 = two BCD digits)
// PORTS
//  clk               in   1   system clock, rising edge
//  rst_n             in   1   synchronous active-low reset
//  tick              in   1   countdown enable; tie high to count every clk
//  G1,Y1,R1          in   1   direction-1 lamps from the light controller
//  G2,Y2,R2          in   1   direction-2 lamps from the light controller
//  Tgreen,Tyellow,Tred in CW  phase durations (same nets as the controller)
//  cnt1,cnt2         out  CW  remaining count, binary
//  bcd1_t,bcd1_o     out  4   dir-1 tens/ones BCD (dir-2: bcd2_t,bcd2_o)
//  seg1_t,seg1_o     out  7   dir-1 tens/ones segments {a..g}, active-high
//  seg2_t,seg2_o     out  7   dir-2 tens/ones segments
//  err1,err2         out  1   illegal lamp pattern on that direction
// BEHAVIOUR
//  - Clock and reset: single clock domain. Reset is synchronous, active-low
//    rst_n. No asynchronous logic.
//  - Phase decode, per direction: exactly one lamp lit -> GREEN, YELLOW or
//    RED. Zero lamps or more than one lamp -> INVALID.
//  - Reset values: phase reg = NONE, cnt = 0, bcd = 0, err = 0.
//    All seg outputs = 7'h00 (blank) until the first valid phase loads.
//  - Load: decoded valid phase != stored phase -> store phase and load cnt.
//    GREEN loads Tgreen, YELLOW loads Tyellow, RED loads Tred.
//    Inputs are sampled at edge n; cnt/bcd/seg are valid after edge n.
//    Latency is 1 clk, all outputs registered.
//  - Decrement: no load, tick=1, cnt>0 -> cnt-1. cnt==0 holds at 0 (no wrap).
//  - Simultaneous load and tick: load wins, value = new duration (no -1).
//  - A load value of 0 shows 0 immediately. A duration change mid-phase has
//    no effect until the next phase entry.
//  - INVALID phase: err=1 while invalid, cnt frozen, stored phase unchanged.
//    On return to a valid phase: err=0. If that phase differs from the
//    stored one, cnt reloads; if it is the same, cnt resumes.
//  - BCD: tens = cnt/10, ones = cnt%10, computed from the next cnt value so
//    bcd/seg align with cnt in the same cycle.
//  - Seg table {a..g}: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B.
//    Codes above 9 are impossible at CW=6; decode them as blank.
//  - Reset mid-countdown: next edge gives reset values. The first valid
//    lamp pattern after reset reloads cnt.
// CONFIGURATION
//  - Macro: CD_LEADING_ZERO_BLANK_EN.
//  - Defined: seg*_t = 7'h00 whenever the tens digit is 0, so 7 shows
//    " 7". bcd*_t still reads 0.
//  - Undefined: tens digit is always shown, so 7 shows "07".
// STRUCTURE
//  - traffic_pkg: phase encoding (NONE, GREEN, YELLOW, RED, INVALID),
//    the SEG_BLANK constant and the 10-entry 7-seg table.
//  - Sub-module seg7_decoder (4-bit BCD -> 7 segments, combinational).
//    Instantiated four times.
//  - Per-direction counter and phase logic is written inline twice, or as a
//    generate loop over index 1..2.
// TESTING
//  1 Reset: hold rst_n=0 for 3 clks with lamps active -> cnt=0, bcd=0,
//    seg=00, err=0.
//  2 G1=1, R2=1, Tgreen=20, Tred=35, tick=1 -> after 1 clk: cnt1=20
//    (seg1_t=6D, seg1_o=7E) and cnt2=35. Then 19 and 34 on the next clk.
//  3 Tyellow=2, enter YELLOW on dir 1, hold 5 clks -> cnt1 = 2,1,0,0,0.
//    Held at 0, no wrap to 63.
//  4 G1=Y1=1 for 2 clks mid-count at cnt1=12 -> err1=1, cnt1 stays 12.
//    Back to G1 only -> err1=0, cnt1 resumes at 11.
//  5 tick=0 for 4 clks -> counts frozen. A lamp change during tick=0 still
//    loads the new duration.
//  6 cnt1 reaches 7: with CD_LEADING_ZERO_BLANK_EN, seg1_t=00 and
//    seg1_o=70. Without it, seg1_t=7E. Also: rst_n=0 at cnt=9 -> 0 next clk.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding, blank code and 7-segment table shared by the countdown display.
package traffic_pkg;
  typedef enum logic [2:0] {NONE, GREEN, YELLOW, RED, INVALID} phase_t;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_TABLE [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                             7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  function automatic phase_t decode_phase(input logic [2:0] gyr);
    return gyr == 3'b100 ? GREEN : gyr == 3'b010 ? YELLOW : gyr == 3'b001 ? RED : INVALID;
  endfunction
endpackage

// File: rtl/traffic_countdown_display_seg7_decoder.sv
// seg7_decoder: 4-bit BCD digit to active-high {a..g} segments, codes above 9 blank.
module seg7_decoder
  import traffic_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = bcd < 4'd10 ? SEG_TABLE[bcd] : SEG_BLANK;
endmodule

// File: rtl/traffic_countdown_display.sv
// traffic_countdown_display: per-direction phase countdown shown as binary, BCD and 7-segment.
// Define CD_LEADING_ZERO_BLANK_EN to blank the tens segments when the tens digit is 0.
module traffic_countdown_display
  import traffic_pkg::*;
#(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          G1,
  input  logic          Y1,
  input  logic          R1,
  input  logic          G2,
  input  logic          Y2,
  input  logic          R2,
  input  logic [CW-1:0] Tgreen,
  input  logic [CW-1:0] Tyellow,
  input  logic [CW-1:0] Tred,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [3:0]    bcd1_t,
  output logic [3:0]    bcd1_o,
  output logic [3:0]    bcd2_t,
  output logic [3:0]    bcd2_o,
  output logic [6:0]    seg1_t,
  output logic [6:0]    seg1_o,
  output logic [6:0]    seg2_t,
  output logic [6:0]    seg2_o,
  output logic          err1,
  output logic          err2
);
  logic [2:0] lamps [2];
  assign lamps[0] = {G1, Y1, R1};
  assign lamps[1] = {G2, Y2, R2};
  for (genvar d = 0; d < 2; d++) begin : g_dir
    phase_t        ph, ph_q;
    logic          load, shown_nx, lead_blank;
    logic [CW-1:0] dur, cnt_nx, cnt_q;
    logic [3:0]    tens, ones, bcd_t_q, bcd_o_q;
    logic [6:0]    dec_t, dec_o, seg_t_q, seg_o_q;
    logic          err_q;
    always_comb begin
      ph       = decode_phase(lamps[d]);
      load     = ph != INVALID && ph != ph_q;
      dur      = ph == GREEN ? Tgreen : ph == YELLOW ? Tyellow : Tred;
      cnt_nx   = load ? dur :
                 (ph != INVALID && tick && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      tens     = 4'(cnt_nx / CW'(10));
      ones     = 4'(cnt_nx % CW'(10));
      // segments stay blank until a valid phase has been stored at least once
      shown_nx = load || ph_q != NONE;
    end
`ifdef CD_LEADING_ZERO_BLANK_EN
    assign lead_blank = tens == 4'd0;
`else
    assign lead_blank = 1'b0;
`endif
    seg7_decoder u_dec_t (.bcd(tens), .seg(dec_t));
    seg7_decoder u_dec_o (.bcd(ones), .seg(dec_o));
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ph_q    <= NONE;
        cnt_q   <= '0;
        bcd_t_q <= '0;
        bcd_o_q <= '0;
        seg_t_q <= SEG_BLANK;
        seg_o_q <= SEG_BLANK;
        err_q   <= 1'b0;
      end else begin
        if (load) ph_q <= ph;
        cnt_q   <= cnt_nx;
        bcd_t_q <= tens;
        bcd_o_q <= ones;
        seg_t_q <= shown_nx && !lead_blank ? dec_t : SEG_BLANK;
        seg_o_q <= shown_nx ? dec_o : SEG_BLANK;
        err_q   <= ph == INVALID;
      end
    end
  end
  assign cnt1   = g_dir[0].cnt_q;
  assign cnt2   = g_dir[1].cnt_q;
  assign bcd1_t = g_dir[0].bcd_t_q;
  assign bcd1_o = g_dir[0].bcd_o_q;
  assign bcd2_t = g_dir[1].bcd_t_q;
  assign bcd2_o = g_dir[1].bcd_o_q;
  assign seg1_t = g_dir[0].seg_t_q;
  assign seg1_o = g_dir[0].seg_o_q;
  assign seg2_t = g_dir[1].seg_t_q;
  assign seg2_o = g_dir[1].seg_o_q;
  assign err1   = g_dir[0].err_q;
  assign err2   = g_dir[1].err_q;
endmodule

// File: tb/tb_traffic_countdown_display.sv
// tb_traffic_countdown_display: vector table, hand sequences and random stimulus against a countdown model.
module tb_traffic_countdown_display;
  logic clk = 1'b0;
  logic rst_n, tick, G1, Y1, R1, G2, Y2, R2;
  logic [5:0] Tgreen, Tyellow, Tred, cnt1, cnt2;
  logic [3:0] bcd1_t, bcd1_o, bcd2_t, bcd2_o;
  logic [6:0] seg1_t, seg1_o, seg2_t, seg2_o;
  logic err1, err2;
  traffic_countdown_display #(.CW(6)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .G1(G1), .Y1(Y1), .R1(R1), .G2(G2), .Y2(Y2), .R2(R2),
    .Tgreen(Tgreen), .Tyellow(Tyellow), .Tred(Tred),
    .cnt1(cnt1), .cnt2(cnt2),
    .bcd1_t(bcd1_t), .bcd1_o(bcd1_o), .bcd2_t(bcd2_t), .bcd2_o(bcd2_o),
    .seg1_t(seg1_t), .seg1_o(seg1_o), .seg2_t(seg2_t), .seg2_o(seg2_o),
    .err1(err1), .err2(err2)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit rn, tk;
    logic [2:0] l1, l2;
    int tg, ty, tr, c1, c2;
    bit e1;
  } vec_t;
  int n_cmp = 0, n_bad = 0;
  int m_ph [2], m_cnt [2];
  bit m_err [2];
  bit [6:0] seg_tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
`ifdef CD_LEADING_ZERO_BLANK_EN
  bit lz_blank = 1'b1;
`else
  bit lz_blank = 1'b0;
`endif
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
    end
  endtask
  function automatic int phase_of(input logic [2:0] l);
    if ($countones(l) != 1) return -1;
    return l[2] ? 1 : l[1] ? 2 : 3;
  endfunction
  // model: phase 0 = nothing stored yet, 1/2/3 = green/yellow/red
  task automatic model_update();
    int dur [4];
    dur = '{0, int'(Tgreen), int'(Tyellow), int'(Tred)};
    for (int d = 0; d < 2; d++) begin
      int p;
      p = phase_of(d == 0 ? {G1, Y1, R1} : {G2, Y2, R2});
      if (!rst_n) begin
        m_ph[d] = 0; m_cnt[d] = 0; m_err[d] = 0;
      end else if (p < 0) begin
        m_err[d] = 1;
      end else begin
        m_err[d] = 0;
        if (p != m_ph[d]) begin
          m_ph[d] = p; m_cnt[d] = dur[p];
        end else if (tick && m_cnt[d] > 0) m_cnt[d]--;
      end
    end
  endtask
  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int t, o, st, so;
      t  = m_cnt[d] / 10;
      o  = m_cnt[d] % 10;
      so = m_ph[d] != 0 ? int'(seg_tbl[o]) : 0;
      st = (m_ph[d] != 0 && !(lz_blank && t == 0)) ? int'(seg_tbl[t]) : 0;
      chk(d == 0 ? "cnt1"   : "cnt2",   int'(d == 0 ? cnt1   : cnt2),   m_cnt[d]);
      chk(d == 0 ? "bcd1_t" : "bcd2_t", int'(d == 0 ? bcd1_t : bcd2_t), t);
      chk(d == 0 ? "bcd1_o" : "bcd2_o", int'(d == 0 ? bcd1_o : bcd2_o), o);
      chk(d == 0 ? "seg1_t" : "seg2_t", int'(d == 0 ? seg1_t : seg2_t), st);
      chk(d == 0 ? "seg1_o" : "seg2_o", int'(d == 0 ? seg1_o : seg2_o), so);
      chk(d == 0 ? "err1"   : "err2",   int'(d == 0 ? err1   : err2),   int'(m_err[d]));
    end
  endtask
  task automatic step(input bit rn, input bit tk, input logic [2:0] a, input logic [2:0] b,
                      input int tg, input int ty, input int tr);
    rst_n = rn; tick = tk;
    {G1, Y1, R1} = a; {G2, Y2, R2} = b;
    Tgreen = 6'(tg); Tyellow = 6'(ty); Tred = 6'(tr);
    @(posedge clk);
    #1;
    model_update();
    check_all();
  endtask
  initial begin
    vec_t v [$];
    logic [2:0] l1, l2;
    int tg, ty, tr;
    rst_n = 0; tick = 0; {G1, Y1, R1} = 3'b000; {G2, Y2, R2} = 3'b000;
    Tgreen = 0; Tyellow = 0; Tred = 0;
    m_ph = '{0, 0}; m_cnt = '{0, 0}; m_err = '{0, 0};
    for (int i = 0; i < 3; i++) v.push_back(vec_t'{0, 1, 3'b100, 3'b001, 20, 2, 35, 0, 0, 0});
    v.push_back(vec_t'{1, 1, 3'b100, 3'b001, 20, 2, 35, 20, 35, 0});
    v.push_back(vec_t'{1, 1, 3'b100, 3'b001, 20, 2, 35, 19, 34, 0});
    v.push_back(vec_t'{1, 1, 3'b010, 3'b001, 20, 2, 35, 2, 33, 0});
    v.push_back(vec_t'{1, 1, 3'b010, 3'b001, 20, 2, 35, 1, 32, 0});
    v.push_back(vec_t'{1, 1, 3'b010, 3'b001, 20, 2, 35, 0, 31, 0});
    v.push_back(vec_t'{1, 1, 3'b010, 3'b001, 20, 2, 35, 0, 30, 0});
    v.push_back(vec_t'{1, 1, 3'b010, 3'b001, 20, 2, 35, 0, 29, 0});
    v.push_back(vec_t'{1, 1, 3'b100, 3'b001, 13, 2, 35, 13, 28, 0});
    v.push_back(vec_t'{1, 1, 3'b100, 3'b001, 13, 2, 35, 12, 27, 0});
    v.push_back(vec_t'{1, 1, 3'b110, 3'b001, 13, 2, 35, 12, 26, 1});
    v.push_back(vec_t'{1, 1, 3'b110, 3'b001, 13, 2, 35, 12, 25, 1});
    v.push_back(vec_t'{1, 1, 3'b100, 3'b001, 13, 2, 35, 11, 24, 0});
    for (int i = 0; i < 3; i++) v.push_back(vec_t'{1, 0, 3'b100, 3'b001, 13, 2, 35, 11, 24, 0});
    v.push_back(vec_t'{1, 0, 3'b001, 3'b001, 13, 2, 35, 35, 24, 0});
    v.push_back(vec_t'{1, 1, 3'b001, 3'b001, 13, 2, 35, 34, 23, 0});
    v.push_back(vec_t'{1, 1, 3'b100, 3'b001, 8, 2, 35, 8, 22, 0});
    v.push_back(vec_t'{1, 1, 3'b100, 3'b001, 8, 2, 35, 7, 21, 0});
    v.push_back(vec_t'{1, 1, 3'b010, 3'b001, 8, 9, 35, 9, 20, 0});
    v.push_back(vec_t'{0, 1, 3'b010, 3'b001, 8, 9, 35, 0, 0, 0});
    v.push_back(vec_t'{1, 1, 3'b010, 3'b001, 8, 9, 35, 9, 35, 0});
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rn, v[i].tk, v[i].l1, v[i].l2, v[i].tg, v[i].ty, v[i].tr);
      chk("vec_cnt1", int'(cnt1), v[i].c1);
      chk("vec_cnt2", int'(cnt2), v[i].c2);
      chk("vec_err1", int'(err1), int'(v[i].e1));
    end
    step(1, 1, 3'b001, 3'b001, 20, 9, 35);
    step(1, 1, 3'b100, 3'b001, 7, 9, 35);
    chk("seven_seg1_o", int'(seg1_o), 'h70);
    chk("seven_seg1_t", int'(seg1_t), lz_blank ? 0 : 'h7E);
    step(1, 1, 3'b100, 3'b000, 7, 9, 35);
    chk("dark_err2", int'(err2), 1);
    step(1, 1, 3'b100, 3'b011, 7, 9, 35);
    chk("double_err2", int'(err2), 1);
    l1 = 3'b100; l2 = 3'b001; tg = 12; ty = 3; tr = 15;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) l1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) l2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) tg = $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) ty = $urandom_range(0, 5);
      if ($urandom_range(0, 9) == 0) tr = $urandom_range(0, 63);
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, l1, l2, tg, ty, tr);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
